outpkt_multi: RTL and testbench

OUTPKT_MULTI -- requirements
Module: outpkt_multi

---
 rtl/outpkt_multi.sv | 259 +++++++++++++++++++++++++
 tb/tb_outpkt_multi.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/outpkt_multi.sv
`ifndef PKT_COMM_VERSION
`define PKT_COMM_VERSION 8'h02
`endif
`default_nettype none
// ============================================================================
// Module  : outpkt_multi
// Purpose : round-robin framer turning per-channel results into a 16-bit
//           word stream with a single-register valid/ready output stage
// Rev     : 1.0
// ============================================================================
module outpkt_multi #(
    parameter logic [7:0] VERSION      = `PKT_COMM_VERSION,
    parameter int         N_SRC        = 4,
    parameter int         RESULT_LEN   = 32,
    parameter int         HASH_NUM_MSB = 15
) (
    input  logic                               CLK,
    input  logic                               RESET_N,
    input  logic [N_SRC-1:0]                   src_not_empty,
    input  logic [2*N_SRC-1:0]                 pkt_type,
    input  logic [16*N_SRC-1:0]                pkt_id,
    input  logic [(HASH_NUM_MSB+1)*N_SRC-1:0]  hash_num,
    input  logic [32*N_SRC-1:0]                num_processed,
    output logic [3:0]                         rd_sel,
    output logic [$clog2(4+RESULT_LEN/2)-1:0]  rd_addr,
    input  logic [15:0]                        din,
    output logic [N_SRC-1:0]                   src_ack,
    output logic [15:0]                        dout,
    output logic                               pkt_new,
    output logic                               pkt_end,
    output logic                               dout_valid,
    input  logic                               dout_ready
);

    localparam int         AW   = $clog2(4 + RESULT_LEN / 2);
    localparam int         HW   = HASH_NUM_MSB + 1;
    localparam logic [7:0] C_RW = 8'(RESULT_LEN / 2);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARB  = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_NUMP = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;
    localparam logic [2:0] S_HNUM = 3'd5;
    localparam logic [2:0] S_RES  = 3'd6;
    localparam logic [2:0] S_ACK  = 3'd7;

    localparam logic [1:0] T_INV  = 2'd0;
    localparam logic [1:0] T_DONE = 2'd1;
    localparam logic [1:0] T_CMP  = 2'd3;

    logic [2:0]       r_state, w_state_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic [3:0]       r_grant, r_ptr, w_arb_grant;
    logic [1:0]       r_type, w_type_arb;
    logic             w_arb_found;
    logic [15:0]      r_dout, w_word, w_id;
    logic             r_pkt_new, r_pkt_end, r_dout_valid;
    logic             w_word_vld, w_word_first, w_word_last, w_load, w_accept;
    logic [31:0]      w_np;
    logic [HW-1:0]    w_hash;
    logic [7:0]       w_len;
    logic [N_SRC-1:0] w_ack;

    // Search starts one past the last served channel, so the previous winner
    // (even if it re-requests during its ack) is considered last.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_grant = '0;
        w_type_arb  = T_INV;
        for (int i = 1; i <= N_SRC; i++) begin
            for (int j = 0; j < N_SRC; j++) begin
                if (!w_arb_found && src_not_empty[j] && (j == (int'(r_ptr) + i) % N_SRC)) begin
                    w_arb_found = 1'b1;
                    w_arb_grant = 4'(j);
                    w_type_arb  = pkt_type[2*j +: 2];
                end
            end
        end
    end

    always_comb begin
        w_id   = '0;
        w_np   = '0;
        w_hash = '0;
        for (int j = 0; j < N_SRC; j++) begin
            if (r_grant == 4'(j)) begin
                w_id   = pkt_id[16*j +: 16];
                w_np   = num_processed[32*j +: 32];
                w_hash = hash_num[HW*j +: HW];
            end
        end
    end

    assign w_load   = w_word_vld & (~r_dout_valid | dout_ready);
    assign w_accept = r_dout_valid & dout_ready;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: if (|src_not_empty) w_state_nxt = S_ARB;
            S_ARB: begin
                w_cnt_nxt   = '0;
                w_state_nxt = w_arb_found ? S_HDR : S_IDLE;
            end
            S_HDR: begin
                if (r_type == T_INV) begin
                    w_state_nxt = S_ACK;
                end else if (w_load) begin
                    if (r_cnt == 8'd4) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (r_type == T_DONE) ? S_NUMP : S_MEM;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            S_NUMP: begin
                if (r_cnt == 8'd2) begin
                    if (w_accept) w_state_nxt = S_ACK;
                end else if (w_load) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_MEM: begin
                if (w_load) begin
                    if (r_cnt == 8'd2) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (r_type == T_CMP) ? S_HNUM : S_RES;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            S_HNUM: begin
                if (w_load) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RES;
                end
            end
            S_RES: begin
                if (r_cnt == C_RW) begin
                    if (w_accept) w_state_nxt = S_ACK;
                end else if (w_load) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        case (r_type)
            T_DONE:  w_len = 8'd4;
            T_CMP:   w_len = 8'(8 + RESULT_LEN);
            default: w_len = 8'(6 + RESULT_LEN);
        endcase
    end

    // rd_addr follows the *next* state so the read lands one cycle before the
    // word is loaded, and freezes automatically while the output is stalled.
    always_comb begin
        w_word       = '0;
        w_word_vld   = 1'b0;
        w_word_first = 1'b0;
        w_word_last  = 1'b0;
        w_ack        = '0;
        rd_addr      = '0;
        case (r_state)
            S_HDR: begin
                w_word_vld   = (r_type != T_INV);
                w_word_first = (r_cnt == 8'd0);
                case (r_cnt)
                    8'd0:    w_word = {8'hD1 + {6'd0, r_type}, VERSION};
                    8'd1:    w_word = 16'h35b9;
                    8'd2:    w_word = {8'h00, w_len};
                    8'd3:    w_word = 16'h0000;
                    default: w_word = w_id;
                endcase
            end
            S_NUMP: begin
                w_word_vld  = (r_cnt < 8'd2);
                w_word_last = (r_cnt == 8'd1);
                w_word      = (r_cnt == 8'd0) ? w_np[15:0] : w_np[31:16];
            end
            S_MEM: begin
                w_word_vld = 1'b1;
                w_word     = din;
            end
            S_HNUM: begin
                w_word_vld = 1'b1;
                w_word     = 16'(w_hash);
            end
            S_RES: begin
                w_word_vld  = (r_cnt < C_RW);
                w_word_last = (r_cnt == C_RW - 8'd1);
                w_word      = din;
            end
            S_ACK: begin
                for (int j = 0; j < N_SRC; j++) w_ack[j] = (r_grant == 4'(j));
            end
            default: w_word = '0;
        endcase
        case (w_state_nxt)
            S_MEM:   rd_addr = (w_cnt_nxt == 8'd0) ? '0 : AW'(w_cnt_nxt + 8'd1);
            S_RES:   rd_addr = (w_cnt_nxt < C_RW) ? AW'(w_cnt_nxt + 8'd4) : '0;
            default: rd_addr = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_grant <= '0;
            r_ptr   <= 4'(N_SRC - 1);
            r_type  <= T_INV;
        end else if (r_state == S_ARB && w_arb_found) begin
            r_grant <= w_arb_grant;
            r_ptr   <= w_arb_grant;
            r_type  <= w_type_arb;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_dout_valid <= 1'b0;
            r_dout       <= '0;
            r_pkt_new    <= 1'b0;
            r_pkt_end    <= 1'b0;
        end else if (!r_dout_valid || dout_ready) begin
            r_dout_valid <= w_word_vld;
            if (w_word_vld) begin
                r_dout    <= w_word;
                r_pkt_new <= w_word_first;
                r_pkt_end <= w_word_last;
            end
        end
    end

    assign rd_sel     = r_grant;
    assign src_ack    = w_ack;
    assign dout       = r_dout;
    assign pkt_new    = r_pkt_new;
    assign pkt_end    = r_pkt_end;
    assign dout_valid = r_dout_valid;

endmodule
`default_nettype wire

// File: tb/tb_outpkt_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_outpkt_multi
// Purpose : scoreboard bench for outpkt_multi (words and acks in one queue)
// Rev     : 1.0
// ============================================================================
module tb_outpkt_multi;

    localparam int         N   = 4;
    localparam int         RL  = 32;
    localparam int         AW  = $clog2(4 + RL / 2);
    localparam logic [7:0] VER = 8'h21;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic [3:0]    src_not_empty;
    logic [7:0]    pkt_type;
    logic [63:0]   pkt_id;
    logic [63:0]   hash_num;
    logic [127:0]  num_processed;
    logic [3:0]    rd_sel;
    logic [AW-1:0] rd_addr;
    logic [15:0]   din;
    logic [3:0]    src_ack;
    logic [15:0]   dout;
    logic          pkt_new, pkt_end, dout_valid, dout_ready;

    logic [1:0]  c_type [N];
    logic [15:0] c_id   [N];
    logic [15:0] c_hash [N];
    logic [31:0] c_np   [N];
    int          req_cnt [N];
    int          ack_cnt [N];

    logic [19:0] exp_q [$];
    int          total = 0;
    int          bad   = 0;
    int          n_words = 0;
    bit          rnd_mode = 1'b0;

    outpkt_multi #(
        .VERSION      (VER),
        .N_SRC        (N),
        .RESULT_LEN   (RL),
        .HASH_NUM_MSB (15)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .src_not_empty (src_not_empty),
        .pkt_type      (pkt_type),
        .pkt_id        (pkt_id),
        .hash_num      (hash_num),
        .num_processed (num_processed),
        .rd_sel        (rd_sel),
        .rd_addr       (rd_addr),
        .din           (din),
        .src_ack       (src_ack),
        .dout          (dout),
        .pkt_new       (pkt_new),
        .pkt_end       (pkt_end),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        pkt_type      = '0;
        pkt_id        = '0;
        hash_num      = '0;
        num_processed = '0;
        src_not_empty = '0;
        for (int i = 0; i < N; i++) begin
            pkt_type[2*i +: 2]       = c_type[i];
            pkt_id[16*i +: 16]       = c_id[i];
            hash_num[16*i +: 16]     = c_hash[i];
            num_processed[32*i +: 32] = c_np[i];
            src_not_empty[i]         = (req_cnt[i] != ack_cnt[i]);
        end
    end

    // Channel memories: ch2 holds 0x0100+a, the others differ in the top nibble.
    function automatic logic [15:0] memf(input logic [3:0] ch, input int a);
        return 16'h0100 + 16'(a) + {ch ^ 4'd2, 12'h000};
    endfunction

    always @(posedge CLK) din <= memf(rd_sel, int'(rd_addr));

    function automatic logic [19:0] wev(input logic f, input logic l, input logic [15:0] w);
        return {2'b00, f, l, w};
    endfunction

    function automatic logic [19:0] aev(input int ch);
        return {1'b1, 15'd0, 4'(1 << ch)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_check(input string nm, input logic [19:0] obs);
        logic [19:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got %h expected nothing", nm, obs);
        end else begin
            e = exp_q.pop_front();
            chk(nm, 32'(obs), 32'(e));
        end
    endtask

    // Expected packet built from the channel's current settings.
    task automatic push_pkt(input int ch);
        logic [1:0] t;
        logic [7:0] len;
        t = c_type[ch];
        if (t == 2'd0) begin
            exp_q.push_back(aev(ch));
            return;
        end
        len = (t == 2'd1) ? 8'd4 : (t == 2'd2) ? 8'(6 + RL) : 8'(8 + RL);
        exp_q.push_back(wev(1'b1, 1'b0, {8'hD1 + {6'd0, t}, VER}));
        exp_q.push_back(wev(1'b0, 1'b0, 16'h35b9));
        exp_q.push_back(wev(1'b0, 1'b0, {8'h00, len}));
        exp_q.push_back(wev(1'b0, 1'b0, 16'h0000));
        exp_q.push_back(wev(1'b0, 1'b0, c_id[ch]));
        if (t == 2'd1) begin
            exp_q.push_back(wev(1'b0, 1'b0, c_np[ch][15:0]));
            exp_q.push_back(wev(1'b0, 1'b1, c_np[ch][31:16]));
        end else begin
            exp_q.push_back(wev(1'b0, 1'b0, memf(4'(ch), 0)));
            exp_q.push_back(wev(1'b0, 1'b0, memf(4'(ch), 2)));
            exp_q.push_back(wev(1'b0, 1'b0, memf(4'(ch), 3)));
            if (t == 2'd3) exp_q.push_back(wev(1'b0, 1'b0, c_hash[ch]));
            for (int k = 0; k < RL / 2; k++)
                exp_q.push_back(wev(1'b0, k == RL / 2 - 1, memf(4'(ch), 4 + k)));
        end
        exp_q.push_back(aev(ch));
    endtask

    task automatic drain(input string nm);
        int cyc;
        bit done;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 600) begin
            @(posedge CLK); #1;
            cyc++;
            done = (exp_q.size() == 0) && (src_not_empty == 4'b0);
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s: timeout with %0d events outstanding", nm, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge CLK);
        #1;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_valid"}, 32'(dout_valid), 32'd0);
        chk({nm, "_dout"},  32'(dout),       32'd0);
        chk({nm, "_flags"}, 32'({pkt_new, pkt_end}), 32'd0);
        chk({nm, "_ack"},   32'(src_ack),    32'd0);
        chk({nm, "_rdsel"}, 32'(rd_sel),     32'd0);
        chk({nm, "_rdaddr"}, 32'(rd_addr),   32'd0);
    endtask

    // dout_ready driver: constant 1 or a coin flip every cycle.
    initial begin
        dout_ready = 1'b1;
        forever begin
            @(posedge CLK); #1;
            dout_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every accepted word and every ack pulse.
    initial begin
        logic        stall_prev;
        logic [19:0] hold_val;
        stall_prev = 1'b0;
        hold_val   = '0;
        forever begin
            @(negedge CLK);
            if (RESET_N) begin
                if (stall_prev)
                    chk("hold", 32'({dout_valid, pkt_new, pkt_end, dout}), 32'(hold_val));
                if (dout_valid && dout_ready) begin
                    n_words++;
                    sb_check("word", {2'b00, pkt_new, pkt_end, dout});
                end
                if (src_ack != 4'b0) begin
                    for (int i = 0; i < N; i++) if (src_ack[i]) ack_cnt[i]++;
                    sb_check("ack", {1'b1, 15'd0, src_ack});
                end
                stall_prev = dout_valid && !dout_ready;
                hold_val   = {1'b0, dout_valid, pkt_new, pkt_end, dout};
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cyc;
        for (int i = 0; i < N; i++) begin
            req_cnt[i] = 0;
            ack_cnt[i] = 0;
        end
        c_type[0] = 2'd1; c_id[0] = 16'h1234; c_hash[0] = 16'h0009; c_np[0] = 32'hAABBCCDD;
        c_type[1] = 2'd0; c_id[1] = 16'h1111; c_hash[1] = 16'h0007; c_np[1] = 32'h0;
        c_type[2] = 2'd3; c_id[2] = 16'h2222; c_hash[2] = 16'h0005; c_np[2] = 32'h0;
        c_type[3] = 2'd1; c_id[3] = 16'h3333; c_hash[3] = 16'h0001; c_np[3] = 32'h01020304;
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_zero("reset");
        RESET_N = 1'b1;
        @(posedge CLK); #1;

        // ch0 PACKET_DONE
        exp_q.push_back(wev(1'b1, 1'b0, 16'hD221));
        exp_q.push_back(wev(1'b0, 1'b0, 16'h35B9));
        exp_q.push_back(wev(1'b0, 1'b0, 16'h0004));
        exp_q.push_back(wev(1'b0, 1'b0, 16'h0000));
        exp_q.push_back(wev(1'b0, 1'b0, 16'h1234));
        exp_q.push_back(wev(1'b0, 1'b0, 16'hCCDD));
        exp_q.push_back(wev(1'b0, 1'b1, 16'hAABB));
        exp_q.push_back(aev(0));
        req_cnt[0]++;
        drain("pd_ch0");

        // ch2 CMP_RESULT, hash 5, mem = 0x0100+a
        exp_q.push_back(wev(1'b1, 1'b0, 16'hD421));
        exp_q.push_back(wev(1'b0, 1'b0, 16'h35B9));
        exp_q.push_back(wev(1'b0, 1'b0, 16'h0028));
        exp_q.push_back(wev(1'b0, 1'b0, 16'h0000));
        exp_q.push_back(wev(1'b0, 1'b0, 16'h2222));
        exp_q.push_back(wev(1'b0, 1'b0, 16'h0100));
        exp_q.push_back(wev(1'b0, 1'b0, 16'h0102));
        exp_q.push_back(wev(1'b0, 1'b0, 16'h0103));
        exp_q.push_back(wev(1'b0, 1'b0, 16'h0005));
        for (int k = 0; k < 16; k++)
            exp_q.push_back(wev(1'b0, k == 15, 16'h0104 + 16'(k)));
        exp_q.push_back(aev(2));
        req_cnt[2]++;
        drain("cmp_ch2");

        // ch1 invalid type: dropped, ack only
        exp_q.push_back(aev(1));
        req_cnt[1]++;
        drain("inv_ch1");
        c_type[1] = 2'd2;

        // all channels requesting right after reset: 0,1,2,3,0
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        push_pkt(0);
        push_pkt(1);
        push_pkt(2);
        push_pkt(3);
        push_pkt(0);
        req_cnt[0] += 2;
        req_cnt[1]++;
        req_cnt[2]++;
        req_cnt[3]++;
        drain("rr_all");

        // random backpressure: last served was ch0, so ch1 then ch2
        rnd_mode = 1'b1;
        push_pkt(1);
        push_pkt(2);
        req_cnt[1]++;
        req_cnt[2]++;
        drain("rnd_ready");
        rnd_mode = 1'b0;
        @(posedge CLK); #1;

        // reset while word 7 of a RESULT packet sits in the output register
        c_type[3] = 2'd2;
        push_pkt(3);
        base = n_words;
        req_cnt[3]++;
        cyc = 0;
        while (n_words < base + 7 && cyc < 200) begin
            @(posedge CLK); #1;
            cyc++;
        end
        chk("words_before_reset", 32'(n_words - base), 32'd7);
        RESET_N = 1'b0;
        #1;
        check_zero("midreset");
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        push_pkt(3);
        drain("resend_ch3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
